// File: rtl/hsid_x_obi_arb.sv
// Two-requester round-robin OBI arbiter for the hsid_x master port, with an in-order
// ID FIFO that routes each rvalid back to the requester that issued the transaction.
package hsid_x_obi_inf_pkg;
  localparam int HSID_WORD_WIDTH = 32;

  typedef struct packed {
    logic                           req;
    logic                           we;
    logic [HSID_WORD_WIDTH/8-1:0]   be;
    logic [HSID_WORD_WIDTH-1:0]     addr;
    logic [HSID_WORD_WIDTH-1:0]     wdata;
  } obi_req_t;

  typedef struct packed {
    logic                       gnt;
    logic                       rvalid;
    logic [HSID_WORD_WIDTH-1:0] rdata;
  } obi_resp_t;
endpackage

module hsid_x_obi_arb
  import hsid_x_obi_inf_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int WORD_WIDTH      = HSID_WORD_WIDTH
) (
  input  logic      clk,
  input  logic      rst_n,
  input  obi_req_t  m0_req_i,
  output obi_resp_t m0_rsp_o,
  input  obi_req_t  m1_req_i,
  output obi_resp_t m1_rsp_o,
  output obi_req_t  obi_req_o,
  input  obi_resp_t obi_rsp_i,
  output logic      err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR   = PW'(MAX_OUTSTANDING - 1);

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } arb_state_t;

  arb_state_t      state_q, state_d;
  logic            locked_id_q, locked_id_d;
  logic            rr_ptr_q;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic            err_q;
  logic            id_fifo_q [MAX_OUTSTANDING];

  logic            sel;
  logic            full;
  logic            accept;
  logic            stall;
  logic            pop;
  logic            head_id;
  logic [WORD_WIDTH-1:0] rdata;

  assign full    = (count_q == FULL_COUNT);
  assign pop     = obi_rsp_i.rvalid & (count_q != '0);
  assign head_id = id_fifo_q[rd_ptr_q];
  assign rdata   = obi_rsp_i.rdata;
  assign err_o   = err_q;

  // A stalled address phase keeps its master until the slave grants it.
  always_comb begin
    sel = 1'b0;
    if (state_q == ARB_LOCKED) begin
      sel = locked_id_q;
    end else if (m0_req_i.req & m1_req_i.req) begin
      sel = rr_ptr_q;
    end else if (m1_req_i.req) begin
      sel = 1'b1;
    end
  end

  always_comb begin
    obi_req_o     = sel ? m1_req_i : m0_req_i;
    obi_req_o.req = (sel ? m1_req_i.req : m0_req_i.req) & ~full;
  end

  assign accept = obi_req_o.req & obi_rsp_i.gnt;
  assign stall  = obi_req_o.req & ~obi_rsp_i.gnt;

  always_comb begin
    m0_rsp_o        = '0;
    m1_rsp_o        = '0;
    m0_rsp_o.gnt    = accept & ~sel;
    m1_rsp_o.gnt    = accept & sel;
    m0_rsp_o.rvalid = pop & ~head_id;
    m1_rsp_o.rvalid = pop & head_id;
    m0_rsp_o.rdata  = rdata;
    m1_rsp_o.rdata  = rdata;
  end

  always_comb begin
    state_d     = state_q;
    locked_id_d = locked_id_q;
    if (accept) begin
      state_d = ARB_OPEN;
    end else if (stall) begin
      state_d     = ARB_LOCKED;
      locked_id_d = sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_OPEN;
      locked_id_q <= 1'b0;
      rr_ptr_q    <= 1'b0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      locked_id_q <= locked_id_d;
      if (accept) begin
        rr_ptr_q <= ~sel;
        wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      // Push and pop in the same cycle leave the occupancy unchanged.
      case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (obi_rsp_i.rvalid && count_q == '0) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      id_fifo_q[wr_ptr_q] <= sel;
    end
  end

endmodule

// File: tb/tb_hsid_x_obi_arb.sv
// Directed bench for hsid_x_obi_arb: a per-cycle vector table followed by a
// hand-written asynchronous-reset sequence.
module tb_hsid_x_obi_arb;
  import hsid_x_obi_inf_pkg::*;

  localparam logic [31:0] WDATA_MASK = 32'h5A5A_0000;

  logic      clk;
  logic      rst_n;
  obi_req_t  m0Req, m1Req, obiReq;
  obi_resp_t m0Rsp, m1Rsp, obiRsp;
  logic      err;

  int checkCount;
  int passCount;

  typedef struct {
    string       name;
    logic        m0Req;
    logic [31:0] m0Addr;
    logic        m1Req;
    logic [31:0] m1Addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        expReq;
    logic        expSel;
    logic        expM0Gnt;
    logic        expM1Gnt;
    logic        expM0Rv;
    logic        expM1Rv;
    logic        expErr;
  } vec_t;

  vec_t vecs[$];

  hsid_x_obi_arb #(
    .MAX_OUTSTANDING(4),
    .WORD_WIDTH(HSID_WORD_WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m0_req_i (m0Req),
    .m0_rsp_o (m0Rsp),
    .m1_req_i (m1Req),
    .m1_rsp_o (m1Rsp),
    .obi_req_o(obiReq),
    .obi_rsp_i(obiRsp),
    .err_o    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string name, logic r0, logic [31:0] a0, logic r1, logic [31:0] a1,
                              logic g, logic rv, logic [31:0] rd, logic eReq, logic eSel,
                              logic eG0, logic eG1, logic eRv0, logic eRv1, logic eErr);
    vec_t v;
    v.name = name;   v.m0Req = r0;   v.m0Addr = a0;  v.m1Req = r1;  v.m1Addr = a1;
    v.gnt = g;       v.rvalid = rv;  v.rdata = rd;   v.expReq = eReq; v.expSel = eSel;
    v.expM0Gnt = eG0; v.expM1Gnt = eG1; v.expM0Rv = eRv0; v.expM1Rv = eRv1; v.expErr = eErr;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
    end else begin
      passCount++;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    m0Req.req   = v.m0Req;
    m0Req.we    = 1'b0;
    m0Req.be    = 4'hF;
    m0Req.addr  = v.m0Addr;
    m0Req.wdata = v.m0Addr ^ WDATA_MASK;
    m1Req.req   = v.m1Req;
    m1Req.we    = 1'b1;
    m1Req.be    = 4'h3;
    m1Req.addr  = v.m1Addr;
    m1Req.wdata = v.m1Addr ^ WDATA_MASK;
    obiRsp.gnt    = v.gnt;
    obiRsp.rvalid = v.rvalid;
    obiRsp.rdata  = v.rdata;
  endtask

  task automatic checkOutput(input vec_t v);
    logic [31:0] expAddr;
    expAddr = v.expSel ? v.m1Addr : v.m0Addr;
    checkVal({v.name, ".req"},    32'(obiReq.req),    32'(v.expReq));
    checkVal({v.name, ".addr"},   obiReq.addr,        expAddr);
    checkVal({v.name, ".wdata"},  obiReq.wdata,       expAddr ^ WDATA_MASK);
    checkVal({v.name, ".we"},     32'(obiReq.we),     32'(v.expSel));
    checkVal({v.name, ".be"},     32'(obiReq.be),     v.expSel ? 32'h3 : 32'hF);
    checkVal({v.name, ".m0gnt"},  32'(m0Rsp.gnt),     32'(v.expM0Gnt));
    checkVal({v.name, ".m1gnt"},  32'(m1Rsp.gnt),     32'(v.expM1Gnt));
    checkVal({v.name, ".m0rv"},   32'(m0Rsp.rvalid),  32'(v.expM0Rv));
    checkVal({v.name, ".m1rv"},   32'(m1Rsp.rvalid),  32'(v.expM1Rv));
    checkVal({v.name, ".m0rdata"}, m0Rsp.rdata,       v.rdata);
    checkVal({v.name, ".m1rdata"}, m1Rsp.rdata,       v.rdata);
    checkVal({v.name, ".err"},    32'(err),           32'(v.expErr));
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    m0Req  = '0;
    m1Req  = '0;
    obiRsp = '0;
    rst_n  = 1'b0;

    //            name           r0 a0        r1 a1        g  rv rdata           req sel g0 g1 v0 v1 err
    vecs.push_back(mk("idle",       0, 32'h100, 0, 32'h200, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t1_acc",     1, 32'h100, 0, 32'h200, 1, 0, 32'h0,        1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("t1_resp",    0, 32'h104, 0, 32'h200, 0, 1, 32'hCAFE,     0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("t2_a",       1, 32'h104, 1, 32'h204, 1, 0, 32'h0,        1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("t2_b",       1, 32'h104, 1, 32'h208, 1, 1, 32'h11,       1, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk("t2_c",       1, 32'h108, 1, 32'h208, 1, 1, 32'h22,       1, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mk("t2_drain",   0, 32'h108, 0, 32'h20C, 0, 1, 32'h33,       0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("t3_pre",     1, 32'h10C, 0, 32'h20C, 1, 0, 32'h0,        1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("t3_stall0",  1, 32'h110, 0, 32'h20C, 0, 0, 32'h0,        1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t3_stall1",  1, 32'h110, 1, 32'h20C, 0, 0, 32'h0,        1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t3_stall2",  1, 32'h110, 1, 32'h20C, 0, 0, 32'h0,        1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t3_acc",     1, 32'h110, 1, 32'h20C, 1, 0, 32'h0,        1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("t3_next_m1", 1, 32'h114, 1, 32'h20C, 1, 0, 32'h0,        1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("t5_pre_pop", 0, 32'h114, 0, 32'h210, 0, 1, 32'h44,       0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("t5_acc_pop", 1, 32'h114, 1, 32'h210, 1, 1, 32'h55,       1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk("t4_fill3",   0, 32'h118, 1, 32'h210, 1, 0, 32'h0,        1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("t4_fill4",   1, 32'h118, 0, 32'h214, 1, 0, 32'h0,        1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("t4_full",    1, 32'h11C, 1, 32'h214, 1, 0, 32'h0,        0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t4_full_pop",1, 32'h11C, 1, 32'h214, 1, 1, 32'h66,       0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk("t4_resume",  1, 32'h11C, 1, 32'h214, 1, 0, 32'h0,        1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("drain0",     0, 32'h11C, 0, 32'h218, 0, 1, 32'h77,       0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("drain1",     0, 32'h11C, 0, 32'h218, 0, 1, 32'h88,       0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("drain2",     0, 32'h11C, 0, 32'h218, 0, 1, 32'h99,       0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("drain3",     0, 32'h11C, 0, 32'h218, 0, 1, 32'hAA,       0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("t6_orphan",  0, 32'h11C, 0, 32'h218, 0, 1, 32'hBB,       0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t6_sticky",  0, 32'h11C, 0, 32'h218, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("t6_sticky2", 1, 32'h11C, 1, 32'h218, 1, 0, 32'h0,        1, 0, 1, 0, 0, 0, 1));

    // Reset state with idle inputs
    #12;
    checkVal("rst.req",   32'(obiReq.req),   32'h0);
    checkVal("rst.m0gnt", 32'(m0Rsp.gnt),    32'h0);
    checkVal("rst.m1gnt", 32'(m1Rsp.gnt),    32'h0);
    checkVal("rst.m0rv",  32'(m0Rsp.rvalid), 32'h0);
    checkVal("rst.m1rv",  32'(m1Rsp.rvalid), 32'h0);
    checkVal("rst.err",   32'(err),          32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      applyStimulus(vecs[i]);
      #3;
      checkOutput(vecs[i]);
    end

    // Lock onto m1 with rr_ptr=1 and one entry outstanding, then reset mid-cycle.
    @(posedge clk);
    #1;
    m0Req.req = 1'b0;
    m1Req.req = 1'b1;
    m1Req.addr = 32'h300;
    obiRsp = '0;
    #3;
    checkVal("rs_stall.req",  32'(obiReq.req), 32'h1);
    checkVal("rs_stall.addr", obiReq.addr,     32'h300);

    @(posedge clk);
    #1;
    m0Req.req  = 1'b1;
    m0Req.addr = 32'h180;
    #1;
    checkVal("rs_locked.addr", obiReq.addr, 32'h300);
    #1;
    rst_n = 1'b0;
    obiRsp.rvalid = 1'b1;
    obiRsp.rdata  = 32'hDD;
    #1;
    checkVal("rs_async.addr", obiReq.addr,      32'h180);
    checkVal("rs_async.err",  32'(err),         32'h0);
    checkVal("rs_async.m0rv", 32'(m0Rsp.rvalid), 32'h0);
    checkVal("rs_async.m1rv", 32'(m1Rsp.rvalid), 32'h0);
    m0Req  = '0;
    m1Req  = '0;
    obiRsp = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    @(posedge clk);
    #1;
    obiRsp.rvalid = 1'b1;
    obiRsp.rdata  = 32'hEE;
    #3;
    checkVal("rs_after.m0rv", 32'(m0Rsp.rvalid), 32'h0);
    checkVal("rs_after.m1rv", 32'(m1Rsp.rvalid), 32'h0);
    checkVal("rs_after.err",  32'(err),          32'h0);
    @(posedge clk);
    #1;
    obiRsp.rvalid = 1'b0;
    #3;
    checkVal("rs_after.err_set", 32'(err), 32'h1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
